// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
// byte_merge works at a fixed maximum width so any WIDTH up to RF_MAX_WIDTH can use it.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE     = 1'b0,
        RF_CLEARING = 1'b1
    } rf_state_t;

    localparam int RF_MAX_WIDTH = 512;
    localparam int RF_MAX_BYTES = RF_MAX_WIDTH / 8;

    // Callers zero-extend their operands and truncate the result back to WIDTH.
    function automatic logic [RF_MAX_WIDTH-1:0] byte_merge(
        input logic [RF_MAX_WIDTH-1:0] old_val,
        input logic [RF_MAX_WIDTH-1:0] new_val,
        input logic [RF_MAX_BYTES-1:0] be
    );
        logic [RF_MAX_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < RF_MAX_BYTES; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear-sweep sequencer: walks an address counter over the whole array,
// one entry per cycle, and reports Busy from a register.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    rf_state_t         state_r;
    rf_state_t         state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;

    // State, counter and busy flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RF_IDLE;
            cnt_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Next-state logic; a Clear seen while sweeping is simply not looked at.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        busy_nxt_s  = busy_r;
        case (state_r)
            RF_IDLE: begin
                if (clear) begin
                    state_nxt_s = RF_CLEARING;
                    cnt_nxt_s   = {ADDR_W{1'b0}};
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = RF_IDLE;
                    busy_nxt_s  = 1'b0;
                end
            end
            RF_CLEARING: begin
                if (cnt_r == ADDR_W'(DEPTH - 1)) begin
                    state_nxt_s = RF_IDLE;
                    cnt_nxt_s   = {ADDR_W{1'b0}};
                    busy_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = RF_CLEARING;
                    cnt_nxt_s   = cnt_r + ADDR_W'(1);
                    busy_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = RF_IDLE;
                cnt_nxt_s   = {ADDR_W{1'b0}};
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    assign busy     = busy_r;
    assign clr_we   = (state_r == RF_CLEARING);
    assign clr_addr = cnt_r;

endmodule

// File: rtl/regfile_param.sv
// Architectural register store: configurable width/depth/read ports, byte
// enables, optional write-to-read bypass and a sequential clear sweep.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int NREAD    = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int NBYTES   = WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    RegWrite,
    input  logic [ADDR_W-1:0]       WriteRegister,
    input  logic [WIDTH-1:0]        WriteData,
    input  logic [NBYTES-1:0]       ByteEn,
    input  logic [NREAD*ADDR_W-1:0] ReadRegister,
    output logic [NREAD*WIDTH-1:0]  ReadData,
    input  logic                    Clear,
    output logic                    Busy
);

    logic [WIDTH-1:0]  regs_r [DEPTH];
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              wr_zero_s;
    logic              wr_en_s;
    logic [WIDTH-1:0]  wr_old_s;
    logic [WIDTH-1:0]  wr_merged_s;

    regfile_clear_ctrl #(
        .DEPTH (DEPTH)
    ) u_clear_ctrl (
        .clk      (clk),
        .reset    (reset),
        .clear    (Clear),
        .busy     (Busy),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    assign wr_zero_s = (ZERO_REG != 0) && (WriteRegister == {ADDR_W{1'b0}});
    // Writes are dropped, not deferred, while the sweep owns the array.
    assign wr_en_s   = RegWrite && !Busy && !wr_zero_s;
    assign wr_old_s  = regs_r[WriteRegister];

    // Merged value shared by the array update and the bypass path.
    always_comb begin
        wr_merged_s = WIDTH'(byte_merge(RF_MAX_WIDTH'(wr_old_s),
                                        RF_MAX_WIDTH'(WriteData),
                                        RF_MAX_BYTES'(ByteEn)));
    end

    // Array storage: sweep writes take priority over (already blocked) user writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (clr_we_s) begin
                regs_r[clr_addr_s] <= {WIDTH{1'b0}};
            end else if (wr_en_s) begin
                regs_r[WriteRegister] <= wr_merged_s;
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [WIDTH-1:0]  rd_s;

        assign ra_s = ReadRegister[p*ADDR_W +: ADDR_W];

        // Zero-latency read port with zero-register forcing and optional bypass.
        always_comb begin
            rd_s = regs_r[ra_s];
            if ((ZERO_REG != 0) && (ra_s == {ADDR_W{1'b0}})) begin
                rd_s = {WIDTH{1'b0}};
            end else if ((BYPASS != 0) && wr_en_s && (ra_s == WriteRegister)) begin
                rd_s = wr_merged_s;
            end else begin
                rd_s = regs_r[ra_s];
            end
        end

        assign ReadData[p*WIDTH +: WIDTH] = rd_s;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench: default 32x32/2-port instance plus a
// 64-bit, 16-deep, 4-port instance sharing the clock and reset.
module tb_regfile_param;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic [9:0]  ReadRegister;
    logic [63:0] ReadData;
    logic        Clear;
    logic        Busy;

    logic         reg_write6;
    logic [3:0]   wreg6;
    logic [63:0]  wdata6;
    logic [7:0]   be6;
    logic [15:0]  rreg6;
    logic [255:0] rdata6;
    logic         clear6;
    logic         busy6;

    int errors;
    int checks;
    int busy_cnt;
    logic [31:0] k;

    regfile_param dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ByteEn        (ByteEn),
        .ReadRegister  (ReadRegister),
        .ReadData      (ReadData),
        .Clear         (Clear),
        .Busy          (Busy)
    );

    regfile_param #(
        .WIDTH (64),
        .DEPTH (16),
        .NREAD (4)
    ) dut6 (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (reg_write6),
        .WriteRegister (wreg6),
        .WriteData     (wdata6),
        .ByteEn        (be6),
        .ReadRegister  (rreg6),
        .ReadData      (rdata6),
        .Clear         (clear6),
        .Busy          (busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (Busy) busy_cnt++;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        RegWrite      = 1'b1;
        WriteRegister = a;
        WriteData     = d;
        ByteEn        = be;
        tick();
        RegWrite = 1'b0;
        ByteEn   = 4'h0;
    endtask

    task automatic rd_chk(input int port, input logic [4:0] a, input logic [31:0] exp, input string tag);
        ReadRegister[port*5 +: 5] = a;
        #1;
        check(tag, {32'h0, ReadData[port*32 +: 32]}, {32'h0, exp});
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        busy_cnt      = 0;
        k             = 32'h01020408;
        reset         = 1'b1;
        RegWrite      = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = 32'h0;
        ByteEn        = 4'h0;
        ReadRegister  = {5'd31, 5'd5};
        Clear         = 1'b0;
        reg_write6    = 1'b0;
        wreg6         = 4'd0;
        wdata6        = 64'h0;
        be6           = 8'h0;
        rreg6         = 16'h0;
        clear6        = 1'b0;

        // Reset state
        #2;
        check("reset_busy", {63'h0, Busy}, 64'h0);
        check("reset_rd", ReadData, 64'h0);
        #10;
        reset = 1'b0;
        tick();

        // 1. Register 0 ignores writes, including through the bypass path
        RegWrite      = 1'b1;
        WriteRegister = 5'd0;
        WriteData     = 32'h000000A0;
        ByteEn        = 4'hF;
        rd_chk(0, 5'd0, 32'h0, "zero_reg_bypass");
        tick();
        RegWrite = 1'b0;
        rd_chk(0, 5'd0, 32'h0, "zero_reg_after");

        // 2. Fill 1..31 and read back neighbours
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i) * k, 4'hF);
            rd_chk(0, 5'(i - 1), 32'(i - 1) * k, $sformatf("fill_p0_r%0d", i - 1));
            rd_chk(1, 5'(i), 32'(i) * k, $sformatf("fill_p1_r%0d", i));
        end
        rd_chk(0, 5'd5, 32'h050A1428, "reg5_value");

        // 3. Byte enables and bypass
        wr(5'd7, 32'h11223344, 4'hF);
        RegWrite      = 1'b1;
        WriteRegister = 5'd7;
        WriteData     = 32'hAABBCCDD;
        ByteEn        = 4'b0101;
        rd_chk(0, 5'd7, 32'h11BB33DD, "bypass_merge");
        rd_chk(1, 5'd6, 32'h060C1830, "bypass_other_port");
        tick();
        RegWrite = 1'b0;
        ByteEn   = 4'h0;
        rd_chk(0, 5'd7, 32'h11BB33DD, "byte_merge_stored");
        wr(5'd7, 32'hFFFFFFFF, 4'h0);
        rd_chk(0, 5'd7, 32'h11BB33DD, "be_zero_noop");

        // 4. Clear sweep
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i) * k, 4'hF);
        end
        busy_cnt = 0;
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("busy_rise", {63'h0, Busy}, 64'h1);
        repeat (4) tick();
        rd_chk(0, 5'd2, 32'h0, "sweep_r2_cleared");
        rd_chk(1, 5'd10, 32'h0A142850, "sweep_r10_kept");
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 32'hFFFFFFFF;
        ByteEn        = 4'hF;
        rd_chk(0, 5'd3, 32'h0, "no_bypass_busy");
        tick();
        RegWrite = 1'b0;
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        RegWrite      = 1'b1;
        WriteRegister = 5'd20;
        tick();
        RegWrite = 1'b0;
        rd_chk(1, 5'd20, 32'h142850A0, "dropped_write_r20");
        rd_chk(0, 5'd3, 32'h0, "dropped_write_r3");
        for (int n = 0; n < 100 && Busy; n++) tick();
        check("sweep_done", {63'h0, Busy}, 64'h0);
        check("busy_cycles32", 64'(busy_cnt), 64'd32);
        for (int a = 0; a < 32; a++) begin
            rd_chk(a % 2, 5'(a), 32'h0, $sformatf("swept_r%0d", a));
        end

        // 5. Asynchronous reset mid-sweep
        wr(5'd20, 32'hCAFEF00D, 4'hF);
        wr(5'd31, 32'h5A5A5A5A, 4'hF);
        ReadRegister = {5'd31, 5'd20};
        #1;
        check("pre_reset_r20", {32'h0, ReadData[31:0]}, 64'hCAFEF00D);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        repeat (10) tick();
        check("mid_sweep_busy", {63'h0, Busy}, 64'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_busy", {63'h0, Busy}, 64'h0);
        check("async_reset_rd", ReadData, 64'h0);
        #1;
        reset = 1'b0;
        tick();
        wr(5'd4, 32'h12345678, 4'hF);
        rd_chk(0, 5'd4, 32'h12345678, "post_reset_write");
        check("post_reset_idle", {63'h0, Busy}, 64'h0);

        // 6. Wide, four-port instance
        reg_write6 = 1'b1;
        wreg6      = 4'd15;
        wdata6     = 64'h0123456789ABCDEF;
        be6        = 8'hFF;
        @(posedge clk);
        #1;
        reg_write6 = 1'b0;
        rreg6      = {4{4'd15}};
        #1;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("wide_port%0d", p), rdata6[p*64 +: 64], 64'h0123456789ABCDEF);
        end
        clear6 = 1'b1;
        @(posedge clk);
        #1;
        clear6 = 1'b0;
        begin
            int n6;
            n6 = 0;
            while (busy6 && n6 < 100) begin
                n6++;
                @(posedge clk);
                #1;
            end
            check("wide_busy_cycles16", 64'(n6), 64'd16);
        end
        check("wide_cleared", rdata6[63:0], 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
